// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard and forwarding controller for the in-order IF/ID/EXE/MEM/WB pipeline.
// A shadow pipeline of destination-register records (one per stage after ID)
// drives the ID-operand forwarding selects, load-use stalls, redirect flushes
// and the global freeze while data memory is busy.
//
// Optional feature: define HAZARD_PERF_EN to build saturating performance
// counters for load-use stalls, redirect flushes and memory freezes. Without
// the macro, no counter registers exist and the perf ports read zero.

module pipe_hazard_ctrl #(
    parameter  int REG_AW     = 5,
    parameter  int FWD_DEPTH  = 3,
    parameter  int LOAD_STAGE = 2,
    localparam int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_en,
    input  logic              id_rs2_en,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_we,
    input  logic              id_is_load,
    input  logic              exe_redirect,
    input  logic              mem_busy,
    output logic              stall_if,
    output logic              stall_id,
    output logic              bubble_exe,
    output logic              flush_if_id,
    output logic              freeze,
    output logic [SEL_W-1:0]  fwd_sel_rs1,
    output logic [SEL_W-1:0]  fwd_sel_rs2,
    output logic [31:0]       perf_lu_cnt,
    output logic [31:0]       perf_flush_cnt,
    output logic [31:0]       perf_mem_cnt
);

    // What the pipeline does this cycle, in priority order (freeze highest).
    typedef enum logic [1:0] {
        ACT_ADVANCE  = 2'd0,
        ACT_LOAD_USE = 2'd1,
        ACT_REDIRECT = 2'd2,
        ACT_FREEZE   = 2'd3
    } action_t;

    // Shadow slot records; index 1 is EXE, 2 is MEM, 3 is WB and so on.
    logic              slot_v  [1:FWD_DEPTH];
    logic [REG_AW-1:0] slot_rd [1:FWD_DEPTH];
    logic              slot_we [1:FWD_DEPTH];
    logic              slot_ld [1:FWD_DEPTH];

    logic [SEL_W-1:0]  rs1_sel;
    logic [SEL_W-1:0]  rs2_sel;
    logic              rs1_lu;
    logic              rs2_lu;
    logic              load_use;
    action_t           action;

    // Find the youngest producer for each operand; a load there that has not
    // yet reached the forwardable slot marks that operand as a load-use hazard.
    always_comb begin
        rs1_sel = '0;
        rs2_sel = '0;
        rs1_lu  = 1'b0;
        rs2_lu  = 1'b0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (id_rs1_en && (id_rs1 != '0) && slot_v[k] && slot_we[k] &&
                (slot_rd[k] == id_rs1)) begin
                rs1_sel = SEL_W'(k);
                rs1_lu  = slot_ld[k] && (k < LOAD_STAGE);
            end
            if (id_rs2_en && (id_rs2 != '0) && slot_v[k] && slot_we[k] &&
                (slot_rd[k] == id_rs2)) begin
                rs2_sel = SEL_W'(k);
                rs2_lu  = slot_ld[k] && (k < LOAD_STAGE);
            end
        end
        load_use = id_valid && (rs1_lu || rs2_lu);
    end

    // Resolve the cycle's action: freeze beats redirect beats load-use.
    always_comb begin
        action = ACT_ADVANCE;
        if (mem_busy) begin
            action = ACT_FREEZE;
        end else if (exe_redirect) begin
            action = ACT_REDIRECT;
        end else if (load_use) begin
            action = ACT_LOAD_USE;
        end
    end

    // Drive the control outputs from the action; reset forces everything low.
    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        bubble_exe  = 1'b0;
        flush_if_id = 1'b0;
        freeze      = 1'b0;
        fwd_sel_rs1 = '0;
        fwd_sel_rs2 = '0;
        if (!rst) begin
            case (action)
                ACT_FREEZE: begin
                    freeze      = 1'b1;
                    stall_if    = 1'b1;
                    stall_id    = 1'b1;
                    fwd_sel_rs1 = rs1_sel;
                    fwd_sel_rs2 = rs2_sel;
                end
                ACT_REDIRECT: begin
                    flush_if_id = 1'b1;
                    bubble_exe  = 1'b1;
                    fwd_sel_rs1 = rs1_sel;
                    fwd_sel_rs2 = rs2_sel;
                end
                ACT_LOAD_USE: begin
                    stall_if   = 1'b1;
                    stall_id   = 1'b1;
                    bubble_exe = 1'b1;
                end
                default: begin
                    fwd_sel_rs1 = rs1_sel;
                    fwd_sel_rs2 = rs2_sel;
                end
            endcase
        end
    end

    // Advance the shadow pipeline exactly as the real one moves: hold on
    // freeze, insert an empty record on a bubble, else capture the ID record.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                slot_v[k]  <= 1'b0;
                slot_rd[k] <= '0;
                slot_we[k] <= 1'b0;
                slot_ld[k] <= 1'b0;
            end
        end else if (action != ACT_FREEZE) begin
            for (int k = FWD_DEPTH; k >= 2; k--) begin
                slot_v[k]  <= slot_v[k-1];
                slot_rd[k] <= slot_rd[k-1];
                slot_we[k] <= slot_we[k-1];
                slot_ld[k] <= slot_ld[k-1];
            end
            if (action == ACT_ADVANCE) begin
                slot_v[1]  <= id_valid;
                slot_rd[1] <= id_rd;
                slot_we[1] <= id_we;
                slot_ld[1] <= id_is_load;
            end else begin
                slot_v[1]  <= 1'b0;
                slot_rd[1] <= '0;
                slot_we[1] <= 1'b0;
                slot_ld[1] <= 1'b0;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] lu_cnt_q;
    logic [31:0] flush_cnt_q;
    logic [31:0] mem_cnt_q;

    // Count stall, flush and freeze cycles, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            lu_cnt_q    <= '0;
            flush_cnt_q <= '0;
            mem_cnt_q   <= '0;
        end else begin
            if ((action == ACT_LOAD_USE) && (lu_cnt_q != 32'hFFFF_FFFF)) begin
                lu_cnt_q <= lu_cnt_q + 32'd1;
            end
            if ((action == ACT_REDIRECT) && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
            if ((action == ACT_FREEZE) && (mem_cnt_q != 32'hFFFF_FFFF)) begin
                mem_cnt_q <= mem_cnt_q + 32'd1;
            end
        end
    end

    assign perf_lu_cnt    = rst ? 32'd0 : lu_cnt_q;
    assign perf_flush_cnt = rst ? 32'd0 : flush_cnt_q;
    assign perf_mem_cnt   = rst ? 32'd0 : mem_cnt_q;
`else
    assign perf_lu_cnt    = 32'd0;
    assign perf_flush_cnt = 32'd0;
    assign perf_mem_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
// Scoreboard bench for pipe_hazard_ctrl. The driver computes the expected
// response from a queue-based model of the instructions in flight after ID
// and pushes it; a monitor pops and compares on the falling clock edge.

module tb_pipe_hazard_ctrl;

    localparam int REG_AW     = 5;
    localparam int FWD_DEPTH  = 3;
    localparam int LOAD_STAGE = 2;
    localparam int SEL_W      = $clog2(FWD_DEPTH + 1);

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              ld;
    } rec_t;

    typedef struct packed {
        logic             stall_if;
        logic             stall_id;
        logic             bubble_exe;
        logic             flush_if_id;
        logic             freeze;
        logic [SEL_W-1:0] sel1;
        logic [SEL_W-1:0] sel2;
        logic [31:0]      lu_cnt;
        logic [31:0]      flush_cnt;
        logic [31:0]      mem_cnt;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_en;
    logic              id_rs2_en;
    logic [REG_AW-1:0] id_rd;
    logic              id_we;
    logic              id_is_load;
    logic              exe_redirect;
    logic              mem_busy;
    logic              stall_if;
    logic              stall_id;
    logic              bubble_exe;
    logic              flush_if_id;
    logic              freeze;
    logic [SEL_W-1:0]  fwd_sel_rs1;
    logic [SEL_W-1:0]  fwd_sel_rs2;
    logic [31:0]       perf_lu_cnt;
    logic [31:0]       perf_flush_cnt;
    logic [31:0]       perf_mem_cnt;

    int   checks;
    int   errors;
    exp_t exp_q[$];
    rec_t pipe[$];
    logic [31:0] m_lu;
    logic [31:0] m_flush;
    logic [31:0] m_mem;

    pipe_hazard_ctrl #(
        .REG_AW    (REG_AW),
        .FWD_DEPTH (FWD_DEPTH),
        .LOAD_STAGE(LOAD_STAGE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rs1_en     (id_rs1_en),
        .id_rs2_en     (id_rs2_en),
        .id_rd         (id_rd),
        .id_we         (id_we),
        .id_is_load    (id_is_load),
        .exe_redirect  (exe_redirect),
        .mem_busy      (mem_busy),
        .stall_if      (stall_if),
        .stall_id      (stall_id),
        .bubble_exe    (bubble_exe),
        .flush_if_id   (flush_if_id),
        .freeze        (freeze),
        .fwd_sel_rs1   (fwd_sel_rs1),
        .fwd_sel_rs2   (fwd_sel_rs2),
        .perf_lu_cnt   (perf_lu_cnt),
        .perf_flush_cnt(perf_flush_cnt),
        .perf_mem_cnt  (perf_mem_cnt)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Position (1 = just behind ID) of the nearest in-flight writer of rs.
    function automatic int youngest(input logic en, input logic [REG_AW-1:0] rs);
        if (!en || rs == '0) return 0;
        for (int i = 0; i < pipe.size(); i++) begin
            if (pipe[i].v && pipe[i].we && pipe[i].rd == rs) return i + 1;
        end
        return 0;
    endfunction

    // True if the producer at position k is a load whose data is not ready yet.
    function automatic logic load_not_ready(input int k);
        if (k == 0) return 1'b0;
        return pipe[k-1].ld && (k < LOAD_STAGE);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // Drive one ID-stage cycle, push its expected response, then step the model.
    task automatic applyStimulus(input logic r, input logic v,
                                 input logic [REG_AW-1:0] rs1, input logic e1,
                                 input logic [REG_AW-1:0] rs2, input logic e2,
                                 input logic [REG_AW-1:0] rd, input logic we,
                                 input logic ld, input logic redir, input logic busy);
        exp_t e;
        int   k1;
        int   k2;
        logic lu;
        rec_t nr;
        rst = r; id_valid = v; id_rs1 = rs1; id_rs1_en = e1; id_rs2 = rs2;
        id_rs2_en = e2; id_rd = rd; id_we = we; id_is_load = ld;
        exe_redirect = redir; mem_busy = busy;
        k1 = youngest(e1, rs1);
        k2 = youngest(e2, rs2);
        lu = v && (load_not_ready(k1) || load_not_ready(k2));
        e = '0;
        if (!r) begin
            e.sel1      = SEL_W'(k1);
            e.sel2      = SEL_W'(k2);
            e.lu_cnt    = m_lu;
            e.flush_cnt = m_flush;
            e.mem_cnt   = m_mem;
            if (busy) begin
                e.freeze = 1'b1; e.stall_if = 1'b1; e.stall_id = 1'b1;
            end else if (redir) begin
                e.flush_if_id = 1'b1; e.bubble_exe = 1'b1;
            end else if (lu) begin
                e.stall_if = 1'b1; e.stall_id = 1'b1; e.bubble_exe = 1'b1;
                e.sel1 = '0; e.sel2 = '0;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < FWD_DEPTH; i++) pipe[i] = '0;
            m_lu = '0; m_flush = '0; m_mem = '0;
        end else begin
`ifdef HAZARD_PERF_EN
            if (e.freeze && m_mem != 32'hFFFF_FFFF) m_mem = m_mem + 1;
            if (e.flush_if_id && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
            if (e.stall_if && !e.freeze && m_lu != 32'hFFFF_FFFF) m_lu = m_lu + 1;
`endif
            if (!busy) begin
                nr = (redir || lu) ? rec_t'(0) : '{v: v, rd: rd, we: we, ld: ld};
                pipe.push_front(nr);
                void'(pipe.pop_back());
            end
        end
        #1;
    endtask

    // Monitor: compare DUT outputs against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("stall_if",       32'(stall_if),    32'(e.stall_if));
            checkOutput("stall_id",       32'(stall_id),    32'(e.stall_id));
            checkOutput("bubble_exe",     32'(bubble_exe),  32'(e.bubble_exe));
            checkOutput("flush_if_id",    32'(flush_if_id), 32'(e.flush_if_id));
            checkOutput("freeze",         32'(freeze),      32'(e.freeze));
            checkOutput("fwd_sel_rs1",    32'(fwd_sel_rs1), 32'(e.sel1));
            checkOutput("fwd_sel_rs2",    32'(fwd_sel_rs2), 32'(e.sel2));
            checkOutput("perf_lu_cnt",    perf_lu_cnt,      e.lu_cnt);
            checkOutput("perf_flush_cnt", perf_flush_cnt,   e.flush_cnt);
            checkOutput("perf_mem_cnt",   perf_mem_cnt,     e.mem_cnt);
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        checks = 0; errors = 0;
        m_lu = '0; m_flush = '0; m_mem = '0;
        for (int i = 0; i < FWD_DEPTH; i++) pipe.push_back('0);
        rst = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs1_en = 1'b0;
        id_rs2_en = 1'b0; id_rd = '0; id_we = 1'b0; id_is_load = 1'b0;
        exe_redirect = 1'b0; mem_busy = 1'b0;
        @(posedge clk);
        #1;
        $display("[TB] start");

        // reset
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1);
        // youngest producer wins: addi x5, add x5, add x6,x5,x5, then use x5
        applyStimulus(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        applyStimulus(0, 1, 5, 1, 0, 0, 5, 1, 0, 0, 0);
        applyStimulus(0, 1, 5, 1, 5, 1, 6, 1, 0, 0, 0);
        applyStimulus(0, 1, 5, 1, 6, 1, 9, 1, 0, 0, 0);
        // load-use: lw x7, then a reader that stalls once and then forwards
        applyStimulus(0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
        applyStimulus(0, 1, 7, 1, 7, 1, 11, 1, 0, 0, 0);
        applyStimulus(0, 1, 7, 1, 7, 1, 11, 1, 0, 0, 0);
        // redirect beats load-use
        applyStimulus(0, 1, 0, 0, 0, 0, 8, 1, 1, 0, 0);
        applyStimulus(0, 1, 8, 1, 0, 0, 12, 1, 0, 1, 0);
        applyStimulus(0, 1, 8, 1, 0, 0, 12, 1, 0, 0, 0);
        // freeze for four cycles with a redirect pending
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 12, 1, 8, 1, 13, 1, 0, 1, 1);
        applyStimulus(0, 1, 12, 1, 8, 1, 13, 1, 0, 1, 0);
        // x0 writer and disabled operands never forward
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 0, 0, 9, 1, 1, 0, 0);
        applyStimulus(0, 1, 0, 1, 9, 0, 14, 1, 0, 0, 0);
        // reset in the middle of a load-use stall
        applyStimulus(0, 1, 0, 0, 0, 0, 10, 1, 1, 0, 0);
        applyStimulus(0, 1, 10, 1, 0, 0, 15, 1, 0, 0, 0);
        applyStimulus(1, 1, 10, 1, 0, 0, 15, 1, 0, 0, 0);
        applyStimulus(0, 1, 10, 1, 0, 0, 15, 1, 0, 0, 0);

        // randomized traffic on a small register set to provoke hazards
        for (int n = 0; n < 600; n++) begin
            applyStimulus(($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 9) != 0),
                          REG_AW'($urandom_range(0, 3)), 1'($urandom),
                          REG_AW'($urandom_range(0, 3)), 1'($urandom),
                          REG_AW'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 9) == 0));
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
